// File: rtl/oitf_tracker_pkg.sv
// ----------------------------------------------------------------------------
// oitf_tracker_pkg
// Shared constants for the outstanding-instruction-track FIFO (OITF).
//   OitfDepth       : default number of outstanding-write entries
//   RegAddrBusWidth : default register-index width
//   OitfWidth       : pointer width for the default depth (index + wrap bit)
// ----------------------------------------------------------------------------
package oitf_tracker_pkg;

    localparam int OitfDepth       = 4;
    localparam int RegAddrBusWidth = 5;
    localparam int OitfWidth       = $clog2(OitfDepth) + 1;

endpackage

// File: rtl/gnrl_dfflr.sv
// ----------------------------------------------------------------------------
// gnrl_dfflr
// Generic load-enable flop with asynchronous active-low reset to zero.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   lden  : load enable
//   dnxt  : next value
//   qout  : registered value
// ----------------------------------------------------------------------------
module gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (lden) begin
            r_q <= dnxt;
        end
    end

    assign qout = r_q;

endmodule

// File: rtl/oitf_tracker_entry.sv
// ----------------------------------------------------------------------------
// oitf_entry
// One OITF entry: valid bit, destination index and (with OITF_HILO_EN) the
// HI/LO write flags, plus its hazard compare against the current queries.
// Query enables are applied by the parent; outputs here are per-entry hits.
//   i_set / i_clr            : allocate into / retire this entry
//   i_rdidx, i_hi, i_lo      : fields captured on allocation
//   i_rs1idx/i_rs2idx/i_rdq  : query indices
//   o_rdidx                  : stored destination index
//   o_m_*                    : per-entry hit (valid and matching)
// Macro OITF_HILO_EN: store hi/lo flags; otherwise o_m_hi/o_m_lo are 0.
// ----------------------------------------------------------------------------
module oitf_entry #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_set,
    input  logic              i_clr,
    input  logic [ADDR_W-1:0] i_rdidx,
    input  logic              i_hi,
    input  logic              i_lo,
    input  logic [ADDR_W-1:0] i_rs1idx,
    input  logic [ADDR_W-1:0] i_rs2idx,
    input  logic [ADDR_W-1:0] i_rdq,
    output logic [ADDR_W-1:0] o_rdidx,
    output logic              o_m_rs1,
    output logic              o_m_rs2,
    output logic              o_m_rd,
    output logic              o_m_hi,
    output logic              o_m_lo
);

    logic              w_vld;
    logic [ADDR_W-1:0] w_rdidx;

    // set and clr never coincide on one entry: that needs full and empty at once
    gnrl_dfflr #(.DW(1)) u_vld (
        .clk(clk), .rst_n(rst_n), .lden(i_set | i_clr), .dnxt(i_set), .qout(w_vld)
    );

    gnrl_dfflr #(.DW(ADDR_W)) u_rdidx (
        .clk(clk), .rst_n(rst_n), .lden(i_set), .dnxt(i_rdidx), .qout(w_rdidx)
    );

`ifdef OITF_HILO_EN
    logic [1:0] w_hilo;

    gnrl_dfflr #(.DW(2)) u_hilo (
        .clk(clk), .rst_n(rst_n), .lden(i_set), .dnxt({i_hi, i_lo}), .qout(w_hilo)
    );

    assign o_m_hi = w_vld & w_hilo[1];
    assign o_m_lo = w_vld & w_hilo[0];
`else
    logic w_unused_hilo;
    assign w_unused_hilo = i_hi ^ i_lo;
    assign o_m_hi = 1'b0;
    assign o_m_lo = 1'b0;
`endif

    assign o_rdidx = w_rdidx;
    assign o_m_rs1 = w_vld & (w_rdidx == i_rs1idx);
    assign o_m_rs2 = w_vld & (w_rdidx == i_rs2idx);
    assign o_m_rd  = w_vld & (w_rdidx == i_rdq);

endmodule

// File: rtl/oitf_tracker.sv
// ----------------------------------------------------------------------------
// oitf_tracker
// Outstanding-instruction-track FIFO for long-latency register writes.
// Entries are allocated in issue order and retired oldest-first; operand and
// destination queries report a hazard against any valid entry.
//   alc_vld/alc_rdidx/alc_hi/alc_lo : allocate request and fields
//   ret_vld                         : retire the oldest entry
//   rs1_en/rs1idx, rs2_en/rs2idx, rd_en/rdidx, readenhi, readenlo : queries
//   match_rs1/rs2/rd/hi/lo          : hazard outputs (from registered state)
//   full, empty, count, ret_rdidx   : occupancy and oldest destination index
// Macro OITF_HILO_EN: enables HI/LO tracking; otherwise match_hi/lo are 0.
// ----------------------------------------------------------------------------
module oitf_tracker
    import oitf_tracker_pkg::*;
#(
    parameter int DEPTH  = OitfDepth,
    parameter int ADDR_W = RegAddrBusWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alc_vld,
    input  logic [ADDR_W-1:0]     alc_rdidx,
    input  logic                  alc_hi,
    input  logic                  alc_lo,
    input  logic                  ret_vld,
    input  logic                  rs1_en,
    input  logic [ADDR_W-1:0]     rs1idx,
    input  logic                  rs2_en,
    input  logic [ADDR_W-1:0]     rs2idx,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rdidx,
    input  logic                  readenhi,
    input  logic                  readenlo,
    output logic                  match_rs1,
    output logic                  match_rs2,
    output logic                  match_rd,
    output logic                  match_hi,
    output logic                  match_lo,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [ADDR_W-1:0]     ret_rdidx
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  w_alc_ptr;
    logic [PTR_W-1:0]  w_ret_ptr;
    logic              w_alc_ok;
    logic              w_ret_ok;
    logic [DEPTH-1:0]  w_m_rs1, w_m_rs2, w_m_rd, w_m_hi, w_m_lo;
    logic [ADDR_W-1:0] w_ent_rdidx [DEPTH];

    assign empty = (w_alc_ptr == w_ret_ptr);
    assign full  = (w_alc_ptr[IDX_W-1:0] == w_ret_ptr[IDX_W-1:0]) &&
                   (w_alc_ptr[PTR_W-1]   != w_ret_ptr[PTR_W-1]);
    assign count = w_alc_ptr - w_ret_ptr;

    // Refusing allocation while full also covers full+alloc+retire: retire only.
    assign w_alc_ok = alc_vld & ~full;
    assign w_ret_ok = ret_vld & ~empty;

    gnrl_dfflr #(.DW(PTR_W)) u_alc_ptr (
        .clk(clk), .rst_n(rst_n), .lden(w_alc_ok),
        .dnxt(w_alc_ptr + PTR_W'(1)), .qout(w_alc_ptr)
    );

    gnrl_dfflr #(.DW(PTR_W)) u_ret_ptr (
        .clk(clk), .rst_n(rst_n), .lden(w_ret_ok),
        .dnxt(w_ret_ptr + PTR_W'(1)), .qout(w_ret_ptr)
    );

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        oitf_entry #(.ADDR_W(ADDR_W)) u_ent (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_set    (w_alc_ok & (w_alc_ptr[IDX_W-1:0] == IDX_W'(i))),
            .i_clr    (w_ret_ok & (w_ret_ptr[IDX_W-1:0] == IDX_W'(i))),
            .i_rdidx  (alc_rdidx),
            .i_hi     (alc_hi),
            .i_lo     (alc_lo),
            .i_rs1idx (rs1idx),
            .i_rs2idx (rs2idx),
            .i_rdq    (rdidx),
            .o_rdidx  (w_ent_rdidx[i]),
            .o_m_rs1  (w_m_rs1[i]),
            .o_m_rs2  (w_m_rs2[i]),
            .o_m_rd   (w_m_rd[i]),
            .o_m_hi   (w_m_hi[i]),
            .o_m_lo   (w_m_lo[i])
        );
    end

    assign ret_rdidx = empty ? '0 : w_ent_rdidx[w_ret_ptr[IDX_W-1:0]];

    assign match_rs1 = rs1_en & (|w_m_rs1);
    assign match_rs2 = rs2_en & (|w_m_rs2);
    assign match_rd  = rd_en  & (|w_m_rd);

`ifdef OITF_HILO_EN
    assign match_hi = readenhi & (|w_m_hi);
    assign match_lo = readenlo & (|w_m_lo);
`else
    logic w_unused_hilo;
    assign w_unused_hilo = ^{readenhi, readenlo, w_m_hi, w_m_lo};
    assign match_hi = 1'b0;
    assign match_lo = 1'b0;
`endif

endmodule

// File: tb/tb_oitf_tracker.sv
// ----------------------------------------------------------------------------
// tb_oitf_tracker
// Directed, table-driven bench for oitf_tracker (DEPTH=4, ADDR_W=5).
// Each row: inputs applied after the falling edge, outputs checked 1 ns later
// (reflecting state from earlier rows), then the rising edge commits the row.
// ----------------------------------------------------------------------------
module tb_oitf_tracker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alc_vld = 0, alc_hi = 0, alc_lo = 0, ret_vld = 0;
    logic [4:0] alc_rdidx = 0, rs1idx = 0, rs2idx = 0, rdidx = 0;
    logic       rs1_en = 0, rs2_en = 0, rd_en = 0, readenhi = 0, readenlo = 0;
    logic       match_rs1, match_rs2, match_rd, match_hi, match_lo, full, empty;
    logic [2:0] count;
    logic [4:0] ret_rdidx;

`ifdef OITF_HILO_EN
    localparam logic HI = 1'b1;
`else
    localparam logic HI = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    oitf_tracker #(.DEPTH(4), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .alc_vld(alc_vld), .alc_rdidx(alc_rdidx), .alc_hi(alc_hi), .alc_lo(alc_lo),
        .ret_vld(ret_vld),
        .rs1_en(rs1_en), .rs1idx(rs1idx), .rs2_en(rs2_en), .rs2idx(rs2idx),
        .rd_en(rd_en), .rdidx(rdidx), .readenhi(readenhi), .readenlo(readenlo),
        .match_rs1(match_rs1), .match_rs2(match_rs2), .match_rd(match_rd),
        .match_hi(match_hi), .match_lo(match_lo),
        .full(full), .empty(empty), .count(count), .ret_rdidx(ret_rdidx)
    );

    typedef struct {
        logic       av; logic [4:0] ai; logic ah; logic al; logic rv;
        logic       q1e; logic [4:0] q1; logic q2e; logic [4:0] q2;
        logic       qde; logic [4:0] qd; logic qh; logic ql;
        logic [2:0] c; logic f; logic e; logic [4:0] rr;
        logic       m1; logic m2; logic md; logic mh; logic ml;
    } vec_t;

    vec_t vecs[64];
    int   nv = 0;

    function automatic void add(
        input logic av, input logic [4:0] ai, input logic ah, input logic al, input logic rv,
        input logic q1e, input logic [4:0] q1, input logic q2e, input logic [4:0] q2,
        input logic qde, input logic [4:0] qd, input logic qh, input logic ql,
        input logic [2:0] c, input logic f, input logic e, input logic [4:0] rr,
        input logic m1, input logic m2, input logic md, input logic mh, input logic ml);
        vecs[nv] = '{av, ai, ah, al, rv, q1e, q1, q2e, q2, qde, qd, qh, ql,
                     c, f, e, rr, m1, m2, md, mh, ml};
        nv++;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s (row %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [2:0] c, input logic f, input logic e,
                             input logic [4:0] rr, input logic m1, input logic m2,
                             input logic md, input logic mh, input logic ml);
        check("count", idx, int'(count), int'(c));
        check("full", idx, int'(full), int'(f));
        check("empty", idx, int'(empty), int'(e));
        check("ret_rdidx", idx, int'(ret_rdidx), int'(rr));
        check("match_rs1", idx, int'(match_rs1), int'(m1));
        check("match_rs2", idx, int'(match_rs2), int'(m2));
        check("match_rd", idx, int'(match_rd), int'(md));
        check("match_hi", idx, int'(match_hi), int'(mh));
        check("match_lo", idx, int'(match_lo), int'(ml));
    endtask

    task automatic idle_inputs();
        alc_vld = 0; alc_rdidx = 0; alc_hi = 0; alc_lo = 0; ret_vld = 0;
        rs1_en = 0; rs1idx = 0; rs2_en = 0; rs2idx = 0; rd_en = 0; rdidx = 0;
        readenhi = 0; readenlo = 0;
    endtask

    initial begin
        // fill: 4 allocations to full, refused 5th, hazard queries
        add(1,1,0,0,0, 1,1,0,0,0,0,0,0, 0,0,1,0, 0,0,0,0,0); // same-cycle alloc not visible
        add(1,2,0,0,0, 1,1,0,0,0,0,0,0, 1,0,0,1, 1,0,0,0,0);
        add(1,3,0,0,0, 0,0,0,0,0,0,0,0, 2,0,0,1, 0,0,0,0,0);
        add(1,4,0,0,0, 0,0,0,0,0,0,0,0, 3,0,0,1, 0,0,0,0,0);
        add(1,5,0,0,0, 1,3,1,7,1,4,0,0, 4,1,0,1, 1,0,1,0,0); // full: 5th refused
        add(0,0,0,0,0, 0,0,0,0,1,5,0,0, 4,1,0,1, 0,0,0,0,0); // 5 never stored
        add(1,6,0,0,1, 0,0,0,0,0,0,0,0, 4,1,0,1, 0,0,0,0,0); // full+alc+ret: retire only
        add(0,0,0,0,1, 1,6,0,0,0,0,0,0, 3,0,0,2, 0,0,0,0,0); // 6 was refused
        add(0,0,0,0,1, 1,3,0,0,0,0,0,0, 2,0,0,3, 1,0,0,0,0);
        add(1,8,0,0,0, 1,3,0,0,0,0,0,0, 1,0,0,4, 0,0,0,0,0); // 3 retired
        // simultaneous alloc+retire at count=2, wrapping pointers
        for (int k = 0; k < 10; k++)
            add(1,9,0,0,1, 0,0,0,0,1,4,0,0, 2,0,0, (k == 0) ? 5'd4 : (k == 1) ? 5'd8 : 5'd9,
                0,0,(k == 0),0,0);
        add(0,0,0,0,1, 0,0,0,0,0,0,0,0, 2,0,0,9, 0,0,0,0,0);
        add(0,0,0,0,1, 0,0,0,0,0,0,0,0, 1,0,0,9, 0,0,0,0,0);
        add(0,0,0,0,1, 0,0,0,0,0,0,0,0, 0,0,1,0, 0,0,0,0,0); // retire while empty
        add(0,0,0,0,0, 1,9,0,0,0,0,0,0, 0,0,1,0, 0,0,0,0,0);
        // HI/LO tracking
        add(1,10,1,0,0, 0,0,0,0,0,0,1,1, 0,0,1,0, 0,0,0,0,0);
        add(0,0,0,0,0,  0,0,0,0,0,0,1,1, 1,0,0,10, 0,0,0,HI,0);
        add(0,0,0,0,1,  0,0,0,0,0,0,1,1, 1,0,0,10, 0,0,0,HI,0);
        add(1,11,0,1,0, 0,0,0,0,0,0,1,1, 0,0,1,0, 0,0,0,0,0);
        add(0,0,0,0,1,  0,0,0,0,0,0,1,1, 1,0,0,11, 0,0,0,0,HI);
        add(0,0,0,0,0,  0,0,0,0,0,0,1,1, 0,0,1,0, 0,0,0,0,0);

        // reset state
        idle_inputs();
        repeat (2) @(negedge clk);
        #1 check_all(-1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nv; i++) begin
            @(negedge clk);
            alc_vld = vecs[i].av; alc_rdidx = vecs[i].ai; alc_hi = vecs[i].ah;
            alc_lo = vecs[i].al; ret_vld = vecs[i].rv;
            rs1_en = vecs[i].q1e; rs1idx = vecs[i].q1; rs2_en = vecs[i].q2e;
            rs2idx = vecs[i].q2; rd_en = vecs[i].qde; rdidx = vecs[i].qd;
            readenhi = vecs[i].qh; readenlo = vecs[i].ql;
            #1 check_all(i, vecs[i].c, vecs[i].f, vecs[i].e, vecs[i].rr,
                         vecs[i].m1, vecs[i].m2, vecs[i].md, vecs[i].mh, vecs[i].ml);
        end

        // mid-operation reset with three outstanding entries
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            idle_inputs();
            alc_vld = 1; alc_rdidx = 5'(k); alc_hi = 1; alc_lo = 1;
        end
        @(negedge clk);
        idle_inputs();
        rs1_en = 1; rs1idx = 1; rs2_en = 1; rs2idx = 2; rd_en = 1; rdidx = 3;
        readenhi = 1; readenlo = 1;
        #1 check_all(100, 3, 0, 0, 1, 1, 1, 1, HI, HI);
        #1 rst_n = 1'b0;
        #1 check_all(101, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ret_vld = 1;
        #1 check_all(102, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 check_all(103, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oitf_tracker.md
OITF_TRACKER -- requirements
Module: oitf_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of outstanding-write entries (power of two, 2..16).
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register-index width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port alc_vld  input  1  request to allocate an entry for an issued long-latency write.
REQ-006 SHALL have port alc_rdidx  input  ADDR_W  destination register index of the allocating instruction.
REQ-007 SHALL have ports alc_hi and alc_lo  input  1 each  allocating instruction writes HI and/or LO.
REQ-008 SHALL have port ret_vld  input  1  writeback of the oldest outstanding write.
REQ-009 SHALL have ports rs1_en/rs1idx, rs2_en/rs2idx and rd_en/rdidx  input  1/ADDR_W  operand-read and destination-write queries.
REQ-010 SHALL have ports readenhi and readenlo  input  1 each  query for a HI/LO read.
REQ-011 SHALL have ports match_rs1, match_rs2, match_rd, match_hi and match_lo  output  1 each  hazard against a valid entry.
REQ-012 SHALL have ports full and empty  output  1 each, and count  output  clog2(DEPTH)+1  number of valid entries.
REQ-013 SHALL have port ret_rdidx  output  ADDR_W  destination index of the oldest valid entry, 0 when empty.

Function
REQ-014 SHALL hold per entry: vld, rdidx, hi and lo bits; circular allocate and retire pointers of clog2(DEPTH)+1 bits (extra wrap bit).
REQ-015 SHALL accept an allocation only when alc_vld=1 and full=0; the entry at the allocate pointer gets vld=1 and its fields at the next edge, and the pointer increments.
REQ-016 SHALL ignore alc_vld while full=1: no state change.
REQ-017 SHALL accept a retirement only when ret_vld=1 and empty=0; it clears vld at the retire pointer and increments the pointer at the next edge.
REQ-018 SHALL ignore ret_vld while empty=1.
REQ-019 SHALL, for simultaneous accepted allocation and retirement, perform both; count is unchanged.
REQ-020 SHALL, when full and alc_vld and ret_vld are all 1, retire only; the allocation is refused.
REQ-021 SHALL wrap pointers modulo 2*DEPTH; full = index bits equal and wrap bits differ; empty = pointers equal.
REQ-022 SHALL drive match_rs1 = rs1_en & OR over valid entries of (rdidx==rs1idx); likewise match_rs2 and match_rd.
REQ-023 SHALL drive match_hi = readenhi & OR over valid entries of hi; likewise match_lo with readenlo and lo.
REQ-024 SHALL compute all match outputs combinationally from registered state; a same-cycle allocation is not visible until the next cycle.
REQ-025 SHALL treat register index 0 like any other index; the issue logic filters index 0.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear all vld bits and both pointers.
REQ-027 SHALL produce these reset output values: empty=1, full=0, count=0, ret_rdidx=0, all match outputs 0.
REQ-028 SHALL, on reset assertion mid-operation, discard all outstanding entries with no retirement reported.

Configuration
REQ-029 SHALL use macro OITF_HILO_EN to control HI/LO tracking.
REQ-030 SHALL, when OITF_HILO_EN is defined, store the hi/lo bits and drive match_hi and match_lo per REQ-023.
REQ-031 SHALL, when OITF_HILO_EN is undefined, omit the per-entry hi/lo storage, ignore alc_hi, alc_lo, readenhi and readenlo, and tie match_hi and match_lo to 0.

Structure
REQ-032 SHALL take default DEPTH, default ADDR_W and pointer-width constants from the shared defines header (OitfDepth, OitfWidth, RegAddrBusWidth).
REQ-033 SHALL build all state from the shared gnrl_dfflr enable flop.
REQ-034 SHALL contain one sub-module, oitf_entry: one entry's storage and its compare against the rs1, rs2, rd, hi and lo queries; instantiated DEPTH times by generate.

Verification
REQ-035 SHALL cover: reset with DEPTH=4, then 4 allocations rdidx 1,2,3,4 -> full=1, count=4; a 5th alc_vld is refused and count stays 4.
REQ-036 SHALL cover: with entries {1,2,3,4}, query rs1idx=3 and rs2idx=7 with both enables set -> match_rs1=1, match_rs2=0; after 3 retirements, match_rs1=0.
REQ-037 SHALL cover: simultaneous alloc (rdidx 9) and ret while count=2 -> count stays 2, ret_rdidx advances to the next-oldest entry; repeat 10 times to wrap the pointers -> no false full or empty.
REQ-038 SHALL cover: ret_vld while empty -> no change, empty=1, count=0.
REQ-039 SHALL cover: with OITF_HILO_EN, allocate with alc_hi=1 then assert readenhi -> match_hi=1 the next cycle and 0 after retirement; without the macro -> match_hi=0 throughout.
REQ-040 SHALL cover: rst_n asserted mid-cycle with count=3 -> outputs immediately take the reset values of REQ-027.
